eddsa_msg_block_loader: RTL and testbench

//   Parametrised message-block feeder between a word-wide host bus and the EdDSA core message port.
//   - Packs WIDTH-bit host words into SIZE_BLOCK-bit blocks; the first word sits in the MSBs.
//   - Zero-fills the tail of the final block, buffers up to DEPTH blocks and counts message length in bits.
//   - Serves blocks on the core's block_ready/block_valid protocol.
//   - Replaces per-block host handling of message/block_valid.

---
 rtl/eddsa_msg_block_loader_pkg.sv | 25 ++
 rtl/eddsa_msg_block_loader_if.sv | 15 +
 rtl/eddsa_block_fifo.sv | 50 +++++
 rtl/eddsa_msg_block_loader.sv | 145 ++++++++++++++
 tb/tb_eddsa_msg_block_loader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eddsa_msg_block_loader_pkg.sv
// Shared encodings, packer state type and default sizes for the EdDSA message-block loader.
package eddsa_pkg;

  localparam int WIDTH_DEF      = 64;
  localparam int SIZE_BLOCK_DEF = 1024;
  localparam int DEPTH_DEF      = 2;
  localparam int LEN_W_DEF      = 64;

  localparam logic [1:0] BLK_IDLE  = 2'b00;
  localparam logic [1:0] BLK_FIRST = 2'b10;
  localparam logic [1:0] BLK_NEXT  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pk_state_t;

  // The first presented block leaves idle as BLK_FIRST; later blocks alternate.
  function automatic logic [1:0] blk_toggle(input logic [1:0] bv);
    return (bv == BLK_FIRST) ? BLK_NEXT : BLK_FIRST;
  endfunction

endpackage

// File: rtl/eddsa_msg_block_loader_if.sv
// Host word stream into the message-block loader: valid/ready with last-word byte count.
interface eddsa_msg_block_loader_if import eddsa_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int NBW = $clog2(WIDTH / 8) + 1;

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [NBW-1:0]   s_nbytes;

  modport master (output s_data, s_valid, s_last, s_nbytes, input s_ready);
  modport slave  (input s_data, s_valid, s_last, s_nbytes, output s_ready);
endinterface

// File: rtl/eddsa_block_fifo.sv
// DEPTH x W synchronous block FIFO; 0-cycle read of the head, push and pop usable together.
// A push into a full FIFO or a pop from an empty one is ignored.
module eddsa_block_fifo #(
  parameter int W     = 1024,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/eddsa_msg_block_loader.sv
// Packs host words MSB-first into zero-filled blocks, buffers them and serves them on block_ready edges.
// Optional EDDSA_LOADER_BSWAP_EN byte-reverses each host word (little-endian hosts).
module eddsa_msg_block_loader import eddsa_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  eddsa_msg_block_loader_if.slave   host,
  input  logic                      block_ready,
  output logic [SIZE_BLOCK-1:0]     message,
  output logic [1:0]                block_valid,
  output logic [LEN_W-1:0]          len_message,
  output logic                      len_valid,
  output logic                      overrun
);
  localparam int NB  = WIDTH / 8;
  localparam int NBW = $clog2(NB) + 1;
  localparam int WPB = SIZE_BLOCK / WIDTH;
  localparam int WCW = (WPB > 1) ? $clog2(WPB) : 1;

  pk_state_t             pstate;
  logic [WCW-1:0]        wc;
  logic [SIZE_BLOCK-1:0] blk_buf, blk_next, push_dat, fifo_rdata;
  logic [WIDTH-1:0]      word_ord, word_msk;
  logic                  run, acc, wc_end, push, pop, req;
  logic                  fifo_full, fifo_empty;
  logic                  br_q, br_qq, pending;

  always_comb begin
    word_ord = host.s_data;
`ifdef EDDSA_LOADER_BSWAP_EN
    for (int i = 0; i < NB; i++) word_ord[WIDTH-1-8*i -: 8] = host.s_data[8*i +: 8];
`endif
    word_msk = word_ord;
    if (host.s_last) begin
      for (int i = 0; i < NB; i++)
        if (NBW'(i) >= host.s_nbytes) word_msk[WIDTH-1-8*i -: 8] = 8'h00;
    end
  end

  always_comb begin
    blk_next = blk_buf;
    blk_next[SIZE_BLOCK-1-int'(wc)*WIDTH -: WIDTH] = word_msk;
  end

  assign wc_end = (wc == WCW'(WPB - 1));
  // Only the block-completing word needs FIFO space; a mid-block s_last parks in FLUSH instead.
  assign host.s_ready = run && (pstate == IDLE || pstate == FILL) && !(fifo_full && wc_end);
  assign acc = host.s_valid && host.s_ready;

  always_comb begin
    push     = 1'b0;
    push_dat = blk_next;
    if (pstate == FLUSH) begin
      push     = !fifo_full;
      push_dat = blk_buf;
    end else if (acc && (wc_end || host.s_last)) begin
      push = !fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pstate      <= IDLE;
      wc          <= '0;
      blk_buf     <= '0;
      len_message <= '0;
      len_valid   <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      case (pstate)
        IDLE, FILL: begin
          if (acc) begin
            len_message <= len_message +
                           (host.s_last ? (LEN_W'(host.s_nbytes) << 3) : LEN_W'(WIDTH));
            if (host.s_last) begin
              len_valid <= 1'b1;
              wc        <= '0;
              if (push) begin
                blk_buf <= '0;
                pstate  <= DONE;
              end else begin
                blk_buf <= blk_next;
                pstate  <= FLUSH;
              end
            end else if (wc_end) begin
              wc      <= '0;
              blk_buf <= '0;
              pstate  <= FILL;
            end else begin
              wc      <= wc + WCW'(1);
              blk_buf <= blk_next;
              pstate  <= FILL;
            end
          end
        end
        FLUSH: begin
          if (!fifo_full) begin
            blk_buf <= '0;
            pstate  <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign req = br_q && !br_qq;
  assign pop = (req || pending) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_q        <= 1'b0;
      br_qq       <= 1'b0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      message     <= '0;
      block_valid <= BLK_IDLE;
    end else begin
      br_q  <= block_ready;
      br_qq <= br_q;
      if (req && pending) overrun <= 1'b1;
      pending <= (req || pending) && fifo_empty;
      if (pop) begin
        message     <= fifo_rdata;
        block_valid <= blk_toggle(block_valid);
      end
    end
  end

  eddsa_block_fifo #(.W(SIZE_BLOCK), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_dat),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_eddsa_msg_block_loader.sv
// Bench: byte-level message model (blocks, length, toggle order) checked against the loader each cycle.
module tb_eddsa_msg_block_loader;
  localparam int WIDTH = 64;
  localparam int SB    = 1024;
  localparam int DEPTH = 2;
  localparam int LW    = 64;
  localparam int NB    = WIDTH / 8;
  localparam int NBW   = $clog2(NB) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            block_ready = 1'b0;
  logic [SB-1:0]   message;
  logic [1:0]      block_valid;
  logic [LW-1:0]   len_message;
  logic            len_valid;
  logic            overrun;

  eddsa_msg_block_loader_if #(.WIDTH(WIDTH)) host ();

  eddsa_msg_block_loader #(.WIDTH(WIDTH), .SIZE_BLOCK(SB), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host),
    .block_ready (block_ready),
    .message     (message),
    .block_valid (block_valid),
    .len_message (len_message),
    .len_valid   (len_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0]    msg [$];
  logic [SB-1:0] exp_q [$];
  logic [LW-1:0] exp_len;
  int            n_pres;
  logic [1:0]    prev_bv;
  logic          prev_lv;
  int            n_chk = 0;
  int            n_pass = 0;
  bit            stalled;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic chk_blk(input string nm, input logic [SB-1:0] act, input logic [SB-1:0] exp);
    bit found;
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      found = 0;
      for (int i = 0; i < SB / 8; i++) begin
        if (!found && act[SB-1-8*i -: 8] !== exp[SB-1-8*i -: 8]) begin
          found = 1;
          $display("FAIL %s: byte %0d got %h, expected %h", nm, i,
                   act[SB-1-8*i -: 8], exp[SB-1-8*i -: 8]);
        end
      end
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired, event not seen", nm);
  endtask

  // Model: message bytes cut into 128-byte blocks, tail zero-filled, at least one block.
  task automatic build_model();
    int n, nblk;
    logic [SB-1:0] blk;
    n = msg.size();
    exp_len = LW'(8 * n);
    nblk = (n == 0) ? 1 : (n + SB / 8 - 1) / (SB / 8);
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int i = 0; i < SB / 8; i++)
        if (b * (SB / 8) + i < n) blk[SB-1-8*i -: 8] = msg[b * (SB / 8) + i];
      exp_q.push_back(blk);
    end
  endtask

  function automatic logic [WIDTH-1:0] pack(input int base, input int cnt);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < cnt; i++) begin
`ifdef EDDSA_LOADER_BSWAP_EN
      w[8*i +: 8] = msg[base + i];
`else
      w[WIDTH-1-8*i -: 8] = msg[base + i];
`endif
    end
    return w;
  endfunction

  task automatic drive_word(input logic [WIDTH-1:0] d, input logic last, input logic [NBW-1:0] nb);
    bit acc_seen;
    acc_seen = 0;
    host.s_data   = d;
    host.s_last   = last;
    host.s_nbytes = nb;
    host.s_valid  = 1'b1;
    for (int c = 0; c < 3000 && !acc_seen; c++) begin
      @(negedge clk);
      acc_seen = host.s_ready;
      if (!acc_seen) stalled = 1;
      @(posedge clk); #1;
    end
    host.s_valid = 1'b0;
    host.s_last  = 1'b0;
    if (!acc_seen) fail_now("word_accept");
  endtask

  task automatic send_msg();
    int n, nw, cnt;
    bit last;
    n = msg.size();
    build_model();
    nw = (n == 0) ? 1 : (n + NB - 1) / NB;
    for (int k = 0; k < nw; k++) begin
      last = (k == nw - 1);
      cnt  = last ? n - NB * k : NB;
      drive_word(pack(NB * k, cnt), last, last ? NBW'(cnt) : NBW'(NB));
    end
  endtask

  task automatic req_edge();
    block_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 block_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_pres(input int target, input int budget, input string nm);
    for (int c = 0; c < budget && n_pres < target; c++) begin
      @(posedge clk); #1;
    end
    if (n_pres < target) fail_now(nm);
  endtask

  task automatic do_reset();
    host.s_valid = 1'b0;
    host.s_last  = 1'b0;
    block_ready  = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    exp_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_test2();
    msg.delete();
    msg = '{8'h89, 8'h01, 8'h0d, 8'h85, 8'h59, 8'h72};
  endtask

  // Every new presentation must be the model's next block with the right toggle value.
  always @(negedge clk) begin
    if (!rst) begin
      prev_bv = 2'b00;
      prev_lv = 1'b0;
      n_pres  = 0;
    end else begin
      if (block_valid !== prev_bv) begin
        chk("block_valid_seq", block_valid, (n_pres % 2 == 0) ? 2'b10 : 2'b01);
        if (exp_q.size() == 0) fail_now("unexpected_block");
        else chk_blk("block_data", message, exp_q.pop_front());
        n_pres++;
        prev_bv = block_valid;
      end
      if (len_valid && !prev_lv) chk("len_message_model", len_message, exp_len);
      prev_lv = len_valid;
    end
  end

  localparam logic [SB-1:0] T2_BLK = {48'h89010d855972, 976'h0};

  initial begin
    host.s_valid  = 1'b0;
    host.s_last   = 1'b0;
    host.s_data   = '0;
    host.s_nbytes = '0;
    exp_len = '0;

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_blk("rst_message", message, '0);
    chk("rst_block_valid", block_valid, 2'b00);
    chk("rst_len", len_message, 0);
    chk("rst_len_valid", len_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_s_ready", host.s_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", host.s_ready, 1);
    @(posedge clk); #1;

    // 2: 48-bit message
    load_test2();
    send_msg();
    req_edge();
    wait_pres(1, 50, "t2_present");
    chk_blk("t2_message", message, T2_BLK);
    chk("t2_block_valid", block_valid, 2'b10);
    chk("t2_len", len_message, 48);
    chk("t2_len_valid", len_valid, 1);
    chk("t2_drained", exp_q.size(), 0);

    // 3: exact full block, then a second request that must stay pending
    do_reset();
    msg.delete();
    for (int i = 0; i < 128; i++) msg.push_back(8'((i * 37 + 11) & 8'hff));
    send_msg();
    req_edge();
    wait_pres(1, 50, "t3_present");
    chk("t3_len", len_message, 1024);
    req_edge();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_one_block", n_pres, 1);
    chk("t3_block_valid", block_valid, 2'b10);
    chk("t3_no_overrun", overrun, 0);

    // 4: 1023-byte message with delayed requests
    do_reset();
    msg.delete();
    for (int i = 0; i < 1023; i++) msg.push_back(8'((i * 13 + 5) & 8'hff));
    stalled = 0;
    fork
      send_msg();
      begin
        repeat (50) @(posedge clk);
        #1;
        for (int r = 0; r < 100 && n_pres < 8; r++) req_edge();
      end
    join
    wait_pres(8, 100, "t4_present");
    chk("t4_stalled", stalled, 1);
    chk("t4_blocks", n_pres, 8);
    chk("t4_len", len_message, 8184);
    chk("t4_last_bv", block_valid, 2'b01);
    chk("t4_tail_byte", message[7:0], 8'h00);
    chk("t4_drained", exp_q.size(), 0);

    // 5: overrun on two requests with an empty FIFO
    do_reset();
    req_edge();
    req_edge();
    chk("t5_overrun", overrun, 1);
    chk("t5_no_block", block_valid, 2'b00);
    load_test2();
    send_msg();
    wait_pres(1, 50, "t5_present");
    repeat (10) @(posedge clk);
    #1;
    chk("t5_once", n_pres, 1);
    chk("t5_block_valid", block_valid, 2'b10);
    chk("t5_overrun_sticky", overrun, 1);

    // 6: reset mid-block, then a fresh message starts at word 0
    do_reset();
    for (int k = 0; k < 5; k++) drive_word(WIDTH'(64'hdead_beef_0000_0000 + 64'(k)), 1'b0, NBW'(0));
    do_reset();
    @(negedge clk);
    chk("t6_block_valid", block_valid, 2'b00);
    chk("t6_len_valid", len_valid, 0);
    chk("t6_len", len_message, 0);
    chk("t6_ready", host.s_ready, 1);
    @(posedge clk); #1;
    load_test2();
    send_msg();
    req_edge();
    wait_pres(1, 50, "t6_present");
    chk_blk("t6_message", message, T2_BLK);
    chk("t6_len_after", len_message, 48);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
